// File: rtl/softreg_host_seq_if.sv
// SoftReg request/response bundle between the host sequencer (master)
// and the accelerator register file (slave). No backpressure: every cycle
// with softreg_req_valid high is a delivered request; writes get no response.
interface softreg_host_seq_if;
   logic        softreg_req_valid;
   logic        softreg_req_isWrite;
   logic [31:0] softreg_req_addr;
   logic [63:0] softreg_req_data;
   logic        softreg_resp_valid;
   logic [63:0] softreg_resp_data;

   modport master (
      output softreg_req_valid, softreg_req_isWrite, softreg_req_addr, softreg_req_data,
      input  softreg_resp_valid, softreg_resp_data
   );

   modport slave (
      input  softreg_req_valid, softreg_req_isWrite, softreg_req_addr, softreg_req_data,
      output softreg_resp_valid, softreg_resp_data
   );
endinterface

// File: rtl/softreg_host_seq.sv
// SoftReg host sequencer for the PageRank accelerator.
// On start: latch cfg_*, write the eight parameter registers on consecutive
// cycles, then poll DONE_ALL until non-zero status, poll limit or timeout.
// Optional macro SOFTREG_SEQ_PERF_EN enables the perf_cycles run-length
// counter; when undefined perf_cycles is tied to 0.
// Register addresses default to a 64-bit-word map; override the ADDR_*
// parameters to match the accelerator's pr_constants.v.
module softreg_host_seq #(
   parameter int unsigned POLL_INTERVAL      = 1024,
   parameter int unsigned MAX_POLLS          = 1000,
   parameter int unsigned RESP_TIMEOUT       = 256,
   parameter logic [31:0] ADDR_N_VERT        = 32'h0000_0000,
   parameter logic [31:0] ADDR_N_INEDGES     = 32'h0000_0008,
   parameter logic [31:0] ADDR_VADDR         = 32'h0000_0010,
   parameter logic [31:0] ADDR_IEADDR        = 32'h0000_0018,
   parameter logic [31:0] ADDR_WRITE_ADDR0   = 32'h0000_0020,
   parameter logic [31:0] ADDR_WRITE_ADDR1   = 32'h0000_0028,
   parameter logic [31:0] ADDR_N_ROUNDS      = 32'h0000_0030,
   parameter logic [31:0] ADDR_DONE_READ_PARAMS = 32'h0000_0038,
   parameter logic [31:0] ADDR_DONE_ALL      = 32'h0000_0040
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] cfg_n_vert,
   input  logic [63:0] cfg_n_inedges,
   input  logic [63:0] cfg_vaddr,
   input  logic [63:0] cfg_ieaddr,
   input  logic [63:0] cfg_write_addr0,
   input  logic [63:0] cfg_write_addr1,
   input  logic [63:0] cfg_n_rounds,
   softreg_host_seq_if.master sr,
   output logic        busy,
   output logic        done,
   output logic [63:0] status,
   output logic [1:0]  error_code,
   output logic [31:0] poll_count,
   output logic [31:0] perf_cycles
);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE, S_ERROR
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   // Entry 7 stays 0: it is the DONE_READ_PARAMS write data.
   logic [7:0][63:0] cfg_q, cfg_d;
   logic [31:0]      wait_cnt_q, wait_cnt_d;
   logic [31:0]      to_cnt_q, to_cnt_d;
   logic [31:0]      poll_cnt_q, poll_cnt_d;
   logic [63:0]      status_q, status_d;
   logic [1:0]       err_q, err_d;
   logic             req_valid_q, req_valid_d;
   logic             req_wr_q, req_wr_d;
   logic [31:0]      req_addr_q, req_addr_d;
   logic [63:0]      req_data_q, req_data_d;

   function automatic logic [31:0] write_addr(input logic [2:0] i);
      case (i)
         3'd0:    write_addr = ADDR_N_VERT;
         3'd1:    write_addr = ADDR_N_INEDGES;
         3'd2:    write_addr = ADDR_VADDR;
         3'd3:    write_addr = ADDR_IEADDR;
         3'd4:    write_addr = ADDR_WRITE_ADDR0;
         3'd5:    write_addr = ADDR_WRITE_ADDR1;
         3'd6:    write_addr = ADDR_N_ROUNDS;
         default: write_addr = ADDR_DONE_READ_PARAMS;
      endcase
   endfunction

   // Next-state logic; the request is derived from the next state so it is
   // registered and appears on the bus in the same cycle as that state.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cfg_d       = cfg_q;
      wait_cnt_d  = wait_cnt_q;
      to_cnt_d    = to_cnt_q;
      poll_cnt_d  = poll_cnt_q;
      status_d    = status_q;
      err_d       = err_q;
      req_valid_d = 1'b0;
      req_wr_d    = 1'b0;
      req_addr_d  = '0;
      req_data_d  = '0;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               cfg_d      = {64'd0, cfg_n_rounds, cfg_write_addr1, cfg_write_addr0,
                             cfg_ieaddr, cfg_vaddr, cfg_n_inedges, cfg_n_vert};
               status_d   = '0;
               err_d      = 2'd0;
               poll_cnt_d = '0;
               idx_d      = 3'd0;
               state_d    = S_WRITE;
            end
         end
         S_WRITE: begin
            if (idx_q == 3'd7) begin
               wait_cnt_d = '0;
               state_d    = S_WAIT;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         S_WAIT: begin
            if (wait_cnt_q + 32'd1 >= POLL_INTERVAL) begin
               poll_cnt_d = poll_cnt_q + 32'd1;
               state_d    = S_RD_REQ;
            end else begin
               wait_cnt_d = wait_cnt_q + 32'd1;
            end
         end
         S_RD_REQ: begin
            // to_cnt holds cycles elapsed since the read request.
            to_cnt_d = 32'd1;
            state_d  = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            // A response in the expiry cycle is still accepted.
            if (sr.softreg_resp_valid) begin
               if (sr.softreg_resp_data != 64'd0) begin
                  status_d = sr.softreg_resp_data;
                  state_d  = S_DONE;
               end else if (poll_cnt_q >= MAX_POLLS) begin
                  err_d   = 2'd2;
                  state_d = S_ERROR;
               end else begin
                  wait_cnt_d = '0;
                  state_d    = S_WAIT;
               end
            end else if (to_cnt_q + 32'd1 >= RESP_TIMEOUT) begin
               err_d   = 2'd1;
               state_d = S_ERROR;
            end else begin
               to_cnt_d = to_cnt_q + 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_WRITE) begin
         req_valid_d = 1'b1;
         req_wr_d    = 1'b1;
         req_addr_d  = write_addr(idx_d);
         req_data_d  = cfg_d[idx_d];
      end else if (state_d == S_RD_REQ) begin
         req_valid_d = 1'b1;
         req_addr_d  = ADDR_DONE_ALL;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cfg_q       <= '0;
         wait_cnt_q  <= '0;
         to_cnt_q    <= '0;
         poll_cnt_q  <= '0;
         status_q    <= '0;
         err_q       <= '0;
         req_valid_q <= 1'b0;
         req_wr_q    <= 1'b0;
         req_addr_q  <= '0;
         req_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cfg_q       <= cfg_d;
         wait_cnt_q  <= wait_cnt_d;
         to_cnt_q    <= to_cnt_d;
         poll_cnt_q  <= poll_cnt_d;
         status_q    <= status_d;
         err_q       <= err_d;
         req_valid_q <= req_valid_d;
         req_wr_q    <= req_wr_d;
         req_addr_q  <= req_addr_d;
         req_data_q  <= req_data_d;
      end
   end

   assign sr.softreg_req_valid   = req_valid_q;
   assign sr.softreg_req_isWrite = req_wr_q;
   assign sr.softreg_req_addr    = req_addr_q;
   assign sr.softreg_req_data    = req_data_q;

   assign busy       = (state_q == S_WRITE) || (state_q == S_WAIT) ||
                       (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
   assign done       = (state_q == S_DONE) || (state_q == S_ERROR);
   assign status     = status_q;
   assign error_code = err_q;
   assign poll_count = poll_cnt_q;

`ifdef SOFTREG_SEQ_PERF_EN
   logic [31:0] perf_q, perf_d;
   logic        perf_start;

   // Run length: loaded with 1 on start so that on the first DONE/ERROR
   // cycle it equals the distance from the start cycle; saturates.
   always_comb begin
      perf_start = start && !busy;
      perf_d     = perf_q;
      if (perf_start) begin
         perf_d = 32'd1;
      end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
         perf_d = perf_q + 32'd1;
      end
   end

   // Performance counter register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_softreg_host_seq.sv
// Self-checking bench for softreg_host_seq: a scoreboard of expected SoftReg
// requests, a scripted DONE_ALL responder, and end-of-run status checks.
`timescale 1ns/1ps
module tb_softreg_host_seq;

   localparam int POLL_I = 16;
   localparam int MAXP   = 4;
   localparam int RTO    = 8;
   localparam logic [31:0] A_DONE_ALL = 32'h0000_0040;

   typedef struct {
      logic        isw;
      logic [31:0] addr;
      logic [63:0] data;
      int          cyc;
   } req_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [63:0] cfg_v [7];
   logic        busy, done;
   logic [63:0] status;
   logic [1:0]  error_code;
   logic [31:0] poll_count, perf_cycles;

   logic        rsp_v = 1'b0, stray_v = 1'b0;
   logic [63:0] rsp_d = '0, stray_d = '0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int prev_rd_cyc = -1;
   int last_rd_cyc = -1;
   int start_cyc = 0;

   req_t        exp_q[$];
   logic [63:0] resp_q[$];
   req_t        mon_e;

   softreg_host_seq_if sr();

   assign sr.softreg_resp_valid = rsp_v | stray_v;
   assign sr.softreg_resp_data  = rsp_v ? rsp_d : (stray_v ? stray_d : 64'd0);

   softreg_host_seq #(
      .POLL_INTERVAL(POLL_I),
      .MAX_POLLS(MAXP),
      .RESP_TIMEOUT(RTO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .cfg_n_vert(cfg_v[0]),
      .cfg_n_inedges(cfg_v[1]),
      .cfg_vaddr(cfg_v[2]),
      .cfg_ieaddr(cfg_v[3]),
      .cfg_write_addr0(cfg_v[4]),
      .cfg_write_addr1(cfg_v[5]),
      .cfg_n_rounds(cfg_v[6]),
      .sr(sr),
      .busy(busy),
      .done(done),
      .status(status),
      .error_code(error_code),
      .poll_count(poll_count),
      .perf_cycles(perf_cycles)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] waddr(input int k);
      case (k)
         0:       waddr = 32'h00;
         1:       waddr = 32'h08;
         2:       waddr = 32'h10;
         3:       waddr = 32'h18;
         4:       waddr = 32'h20;
         5:       waddr = 32'h28;
         6:       waddr = 32'h30;
         default: waddr = 32'h38;
      endcase
   endfunction

   // Request monitor: pops the scoreboard on every delivered request.
   always @(negedge clk) begin
      if (sr.softreg_req_valid) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_req", 64'(exp_q.size()), 64'd1);
         end else begin
            mon_e = exp_q.pop_front();
            $display("req cyc=%0d wr=%0b addr=0x%h data=0x%0h", cyc,
                     sr.softreg_req_isWrite, sr.softreg_req_addr, sr.softreg_req_data);
            check_val("req_iswrite", 64'(sr.softreg_req_isWrite), 64'(mon_e.isw));
            check_val("req_addr", 64'(sr.softreg_req_addr), 64'(mon_e.addr));
            check_val("req_data", sr.softreg_req_data, mon_e.data);
            if (mon_e.cyc >= 0) check_val("req_cycle", 64'(cyc), 64'(mon_e.cyc));
            if (!mon_e.isw) begin
               if (prev_rd_cyc >= 0)
                  check_val("poll_spacing", 64'((cyc - prev_rd_cyc - 1) >= POLL_I), 64'd1);
               prev_rd_cyc = cyc;
               last_rd_cyc = cyc;
            end
         end
      end else begin
         check_val("idle_bus_zero",
                   64'(sr.softreg_req_isWrite) | 64'(sr.softreg_req_addr) | sr.softreg_req_data,
                   64'd0);
      end
   end

   // Scripted responder: answers a read two cycles later with the next
   // scripted value; stays silent when the script is empty.
   initial begin
      int pend_cnt;
      logic [63:0] pend_data;
      pend_cnt = 0;
      pend_data = '0;
      forever begin
         @(negedge clk);
         rsp_v = 1'b0;
         rsp_d = '0;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               rsp_v = 1'b1;
               rsp_d = pend_data;
            end
         end
         if (rst && sr.softreg_req_valid && !sr.softreg_req_isWrite && resp_q.size() > 0) begin
            pend_data = resp_q.pop_front();
            pend_cnt  = 2;
         end
      end
   end

   task automatic do_start(input int n_writes);
      req_t e;
      int s;
      s = cyc;
      for (int k = 0; k < n_writes; k++) begin
         e.isw  = 1'b1;
         e.addr = waddr(k);
         e.data = (k == 7) ? 64'd0 : cfg_v[k];
         e.cyc  = s + 1 + k;
         exp_q.push_back(e);
      end
      prev_rd_cyc = -1;
      start_cyc = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("busy_after_start", 64'(busy), 64'd1);
   endtask

   task automatic push_reads(input int n);
      req_t e;
      for (int k = 0; k < n; k++) begin
         e.isw  = 1'b0;
         e.addr = A_DONE_ALL;
         e.data = 64'd0;
         e.cyc  = -1;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done(input int budget, output int dcyc);
      dcyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            dcyc = cyc;
            break;
         end
      end
      if (dcyc < 0) check_val("done_within_budget", 64'd0, 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      logic [63:0] exp_perf;
      for (int k = 0; k < 7; k++) cfg_v[k] = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_done", 64'(done), 64'd0);
      check_val("rst_status", status, 64'd0);
      check_val("rst_error", 64'(error_code), 64'd0);
      check_val("rst_poll", 64'(poll_count), 64'd0);
      check_val("rst_perf", 64'(perf_cycles), 64'd0);
      check_val("rst_req_valid", 64'(sr.softreg_req_valid), 64'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Run 1: parameter writes, then 0, 0, 1 from DONE_ALL
      cfg_v[0] = 64'd1000;  cfg_v[1] = 64'd5417;  cfg_v[2] = 64'd0;
      cfg_v[3] = 64'd16000; cfg_v[4] = 64'd59336; cfg_v[5] = 64'd67336;
      cfg_v[6] = 64'd0;
      do_start(8);
      push_reads(3);
      resp_q.push_back(64'd0); resp_q.push_back(64'd0); resp_q.push_back(64'd1);
      wait_done(400, d);
      check_val("r1_status", status, 64'd1);
      check_val("r1_done", 64'(done), 64'd1);
      check_val("r1_busy", 64'(busy), 64'd0);
      check_val("r1_poll", 64'(poll_count), 64'd3);
      check_val("r1_error", 64'(error_code), 64'd0);
`ifdef SOFTREG_SEQ_PERF_EN
      exp_perf = 64'(d - start_cyc);
`else
      exp_perf = 64'd0;
`endif
      check_val("r1_perf", 64'(perf_cycles), exp_perf);
      repeat (5) @(negedge clk);
      check_val("r1_done_sticky", 64'(done), 64'd1);
      check_val("r1_status_sticky", status, 64'd1);
      check_val("r1_perf_frozen", 64'(perf_cycles), exp_perf);
      check_val("r1_sb_drained", 64'(exp_q.size()), 64'd0);

      // Run 2: no response -> timeout
      for (int k = 0; k < 7; k++) cfg_v[k] = {$urandom, $urandom};
      do_start(8);
      push_reads(1);
      wait_done(400, d);
      check_val("r2_timeout_latency", 64'(d - last_rd_cyc), 64'(RTO));
      check_val("r2_error", 64'(error_code), 64'd1);
      check_val("r2_status", status, 64'd0);
      check_val("r2_poll", 64'(poll_count), 64'd1);
      check_val("r2_busy", 64'(busy), 64'd0);
      check_val("r2_sb_drained", 64'(exp_q.size()), 64'd0);

      // Run 3: always zero -> poll limit; stray responses and start ignored
      for (int k = 0; k < 7; k++) cfg_v[k] = {$urandom, $urandom};
      do_start(8);
      push_reads(MAXP);
      for (int k = 0; k < MAXP; k++) resp_q.push_back(64'd0);
      stray_v = 1'b1; stray_d = 64'h5;
      @(negedge clk);
      stray_v = 1'b0;
      repeat (9) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stray_v = 1'b1; stray_d = 64'h9;
      @(negedge clk);
      stray_v = 1'b0;
      wait_done(600, d);
      check_val("r3_error", 64'(error_code), 64'd2);
      check_val("r3_done", 64'(done), 64'd1);
      check_val("r3_status", status, 64'd0);
      check_val("r3_poll", 64'(poll_count), 64'(MAXP));
      check_val("r3_sb_drained", 64'(exp_q.size()), 64'd0);

      // Run 4: reset during the 4th write, then a full replay
      for (int k = 0; k < 7; k++) cfg_v[k] = {$urandom, $urandom};
      do_start(4);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      stray_v = 1'b1; stray_d = 64'h3;
      @(negedge clk);
      stray_v = 1'b0;
      check_val("r4_rst_req_valid", 64'(sr.softreg_req_valid), 64'd0);
      check_val("r4_rst_busy", 64'(busy), 64'd0);
      check_val("r4_rst_done", 64'(done), 64'd0);
      check_val("r4_rst_status", status, 64'd0);
      check_val("r4_rst_error", 64'(error_code), 64'd0);
      check_val("r4_rst_poll", 64'(poll_count), 64'd0);
      check_val("r4_rst_perf", 64'(perf_cycles), 64'd0);
      check_val("r4_sb_partial", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 7; k++) cfg_v[k] = {$urandom, $urandom};
      do_start(8);
      push_reads(1);
      resp_q.push_back(64'd7);
      wait_done(400, d);
      check_val("r4_status", status, 64'd7);
      check_val("r4_poll", 64'(poll_count), 64'd1);
      check_val("r4_error", 64'(error_code), 64'd0);
      check_val("r4_sb_drained", 64'(exp_q.size()), 64'd0);
      check_val("resp_script_drained", 64'(resp_q.size()), 64'd0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/softreg_host_seq.md
Name: softreg_host_seq

Overview:
- Synthesizable SoftReg initiator: the host side of the SoftReg request/response interface that the PageRank accelerator responds to.
- On `start`, it latches a configuration set and issues the parameter-write sequence to the accelerator.
- It then polls `DONE_ALL` by SoftReg reads until the accelerator reports a non-zero status, a poll limit is hit, or a read times out.
- It replaces hand-coded testbench stimulus and serves as the on-chip bring-up driver.

Parameters:
- POLL_INTERVAL, 1024, idle cycles between end of one `DONE_ALL` poll and the next read request.
- MAX_POLLS, 1000, number of zero-valued `DONE_ALL` responses tolerated before error.
- RESP_TIMEOUT, 256, cycles waited for `softreg_resp_valid` after a read request.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a run when not busy.
- cfg_n_vert  input  64  value written to `` `N_VERT ``.
- cfg_n_inedges  input  64  value written to `` `N_INEDGES ``.
- cfg_vaddr  input  64  value written to `` `VADDR ``.
- cfg_ieaddr  input  64  value written to `` `IEADDR ``.
- cfg_write_addr0  input  64  value written to `` `WRITE_ADDR0 ``.
- cfg_write_addr1  input  64  value written to `` `WRITE_ADDR1 ``.
- cfg_n_rounds  input  64  value written to `` `N_ROUNDS ``.
- softreg_req_valid  output  1  request strobe, one cycle per request.
- softreg_req_isWrite  output  1  1 = write, 0 = read.
- softreg_req_addr  output  32  register address (`pr_constants.v` macros).
- softreg_req_data  output  64  write data; 0 on reads.
- softreg_resp_valid  input  1  read response strobe.
- softreg_resp_data  input  64  read response data.
- busy  output  1  high from accepted start until DONE/ERROR.
- done  output  1  high in DONE or ERROR; sticky until next start or reset.
- status  output  64  last non-zero `DONE_ALL` data; 0 on error.
- error_code  output  2  0 none, 1 response timeout, 2 poll limit.
- poll_count  output  32  `DONE_ALL` reads issued in current/last run.
- perf_cycles  output  32  see Optional Feature.

Behaviour:
- Reset (`rst`==0 at posedge):
  - state to IDLE; all outputs 0; config latches and counters cleared.
  - Applies mid-operation with no trailing request.
  - A response arriving during reset is dropped.
- Request outputs are registered; address/data/isWrite are 0 whenever `softreg_req_valid`==0.
- SoftReg has no backpressure: every asserted request cycle is a delivered request.
- Writes produce no response.
- States: IDLE, WRITE, WAIT, RD_REQ, RD_WAIT, DONE, ERROR.
- IDLE/DONE/ERROR + `start`:
  - latch all `cfg_*` into registers;
  - clear `done`, `status`, `error_code`, `poll_count`;
  - `busy`=1; go to WRITE with index 0.
- `start` while `busy` is ignored.
- WRITE: one write per cycle on consecutive cycles (first request the cycle after start), in this order:
  - `N_VERT`, `N_INEDGES`, `VADDR`, `IEADDR`, `WRITE_ADDR0`, `WRITE_ADDR1`, `N_ROUNDS`, then `DONE_READ_PARAMS` with data 0.
  - After index 7, go to WAIT.
- WAIT: 3-bit index, 8 writes total; counter counts POLL_INTERVAL cycles, then RD_REQ.
- RD_REQ: one-cycle read of `DONE_ALL`; `poll_count`+1; go to RD_WAIT; clear timeout counter.
- RD_WAIT:
  - on `softreg_resp_valid`:
    - data≠0: `status`=data, DONE;
    - data==0 and `poll_count`==MAX_POLLS: `error_code`=2, ERROR;
    - otherwise WAIT.
  - no response after RESP_TIMEOUT cycles: `error_code`=1, ERROR.
  - Response and timeout expiry in the same cycle: response wins.
- `softreg_resp_valid` in any state other than RD_WAIT is ignored.
- DONE/ERROR: `busy`=0, `done`=1; hold until start or reset.
- Counters are 32-bit and do not wrap within limits (MAX_POLLS < 2^32).

Optional Feature:
- Macro: `SOFTREG_SEQ_PERF_EN`.
- Defined: `perf_cycles` counts clk cycles from the cycle after an accepted start until entry to DONE/ERROR inclusive. It freezes at that value, clears on start or reset, and saturates at 0xFFFFFFFF.
- Undefined: `perf_cycles` is tied to 0 and no counter logic is present.

Test Plan:
- Reset, then start with cfg = 1000, 5417, 0, 16000, 59336, 67336, 0 → eight consecutive write cycles starting 1 cycle after start, with exactly these addr/data and finally `DONE_READ_PARAMS`/0; `busy`=1.
- Responder returns 0 twice then 1, POLL_INTERVAL=16 → three reads spaced ≥16 idle cycles apart; `status`=1, `done`=1, `poll_count`=3, `error_code`=0.
- No response, RESP_TIMEOUT=8 → ERROR exactly 8 cycles after the read request; `error_code`=1, `status`=0.
- MAX_POLLS=4, always responds 0 → 4 reads, then `error_code`=2, `done`=1; start pulse mid-run ignored; stray `resp_valid` during WRITE ignored.
- `rst` low during the 4th write → next cycle `req_valid`=0, all outputs 0; a new start replays the full sequence from `N_VERT`.
- With `SOFTREG_SEQ_PERF_EN`, case 2 → `perf_cycles` equals the measured start-to-DONE cycles; without the macro → `perf_cycles` stays 0.
